// File: rtl/dmem_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_rsp_pkg
// Brief  : Shared constants and FSM encoding for the dmem_responder slice.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_rsp_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder_if
// Brief  : Request/response valid-ready channels between a load/store initiator and the responder.
// Rev    : 1.0  initial release
// ============================================================================
interface dmem_responder_if #(
    parameter int ADR_W  = 5,
    parameter int DATA_W = dmem_rsp_pkg::DATA_W
);
    import dmem_rsp_pkg::*;

    logic                  ReqValid;
    logic                  ReqReady;
    logic                  ReqWrite;
    logic [ADR_W-1:0]      ReqAdr;
    logic [DATA_W-1:0]     ReqWData;
    logic [DATA_W/8-1:0]   ReqBe;
    logic                  RspValid;
    logic                  RspReady;
    logic [DATA_W-1:0]     RspRData;
    logic                  RspWrite;

    modport master (
        output ReqValid, ReqWrite, ReqAdr, ReqWData, ReqBe, RspReady,
        input  ReqReady, RspValid, RspRData, RspWrite
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAdr, ReqWData, ReqBe, RspReady,
        output ReqReady, RspValid, RspRData, RspWrite
    );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module : dmem_array
// Brief  : Word storage with per-byte synchronous write and combinational read; never reset.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_array
    import dmem_rsp_pkg::*;
#(
    parameter int ADR_W  = 5,
    parameter int DATA_W = dmem_rsp_pkg::DATA_W
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADR_W-1:0]      adr_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int DEPTH  = 2 ** ADR_W;
    localparam int NUM_BE = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NUM_BE; i++) begin
                if (be_i[i]) begin
                    mem_q[adr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[adr_i];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder
// Brief  : Stallable data-memory responder: accept, wait states, access, hold response.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_rsp_pkg::*;
#(
    parameter int ADR_W       = 5,
    parameter int DATA_W      = dmem_rsp_pkg::DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    dmem_responder_if.slave    mem_if
);

    localparam int                NUM_BE   = DATA_W / 8;
    localparam logic [WCNT_W-1:0] CNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]        state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NUM_BE-1:0] be_q, be_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_write_q, rsp_write_d;

    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    // Only the captured request drives the array; bus fields are ignored after accept.
    assign arr_we = (state_q == ST_ACCESS) && wr_q;

    dmem_array #(
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (Clk),
        .we_i    (arr_we),
        .adr_i   (adr_q),
        .be_i    (be_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_write_d = rsp_write_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_if.ReqValid && req_ready_q) begin
                    wr_d    = mem_if.ReqWrite;
                    adr_d   = mem_if.ReqAdr;
                    wdata_d = mem_if.ReqWData;
                    be_d    = mem_if.ReqBe;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_write_d = wr_q;
                rsp_rdata_d = wr_q ? '0 : arr_rdata;
            end
            ST_RESP: begin
                if (mem_if.RspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so no input reaches them combinationally.
    assign req_ready_d = (state_d == ST_IDLE);
    assign rsp_valid_d = (state_d == ST_RESP);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    assign mem_if.ReqReady = req_ready_q;
    assign mem_if.RspValid = rsp_valid_q;
    assign mem_if.RspRData = rsp_rdata_q;
    assign mem_if.RspWrite = rsp_write_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_responder
// Brief  : Self-checking bench: directed table, stall/reset corners, random traffic, zero-wait throughput.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int W = 2;

    logic Clk;
    logic Reset;

    dmem_responder_if #(.ADR_W(5), .DATA_W(32)) bus ();
    dmem_responder_if #(.ADR_W(5), .DATA_W(32)) b0 ();

    dmem_responder #(.ADR_W(5), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .mem_if (bus)
    );

    dmem_responder #(.ADR_W(5), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .Clk    (Clk),
        .Reset  (Reset),
        .mem_if (b0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [32];

    typedef struct {
        logic        wr;
        logic [4:0]  adr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void model_store(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (bus.ReqReady !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " ready"}, {31'd0, bus.ReqReady}, 32'd1);
    endtask

    // One full transaction on the WAIT_CYCLES=2 responder, optionally stalling the response.
    task automatic xact(input logic wr, input logic [4:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rd, input int stall, input string nm);
        int n;
        logic [31:0] held;
        wait_ready(nm);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = wr;
        bus.ReqAdr   = a;
        bus.ReqWData = wd;
        bus.ReqBe    = be;
        bus.RspReady = (stall == 0);
        tick();
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'($urandom);
        bus.ReqAdr   = 5'($urandom);
        bus.ReqWData = $urandom;
        bus.ReqBe    = 4'($urandom);
        n = 0;
        while (bus.RspValid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, n, W + 1);
        held = bus.RspRData;
        for (int i = 0; i < stall; i++) begin
            bus.ReqValid = 1'b1;
            tick();
            chk({nm, " stall valid"}, {31'd0, bus.RspValid}, 32'd1);
            chk({nm, " stall data"}, bus.RspRData, held);
            chk({nm, " stall ready"}, {31'd0, bus.ReqReady}, 32'd0);
        end
        bus.ReqValid = 1'b0;
        bus.RspReady = 1'b1;
        chk({nm, " rdata"}, bus.RspRData, wr ? 32'd0 : exp_rd);
        chk({nm, " rwrite"}, {31'd0, bus.RspWrite}, {31'd0, wr});
        tick();
        chk({nm, " ready after"}, {31'd0, bus.ReqReady}, 32'd1);
        chk({nm, " valid after"}, {31'd0, bus.RspValid}, 32'd0);
        if (wr) model_store(a, wd, be);
    endtask

    int          acc_q [$];
    int          rsp_q [$];
    logic [31:0] rdv_q [$];
    logic        rwv_q [$];
    logic        r_wr;
    logic [4:0]  r_adr;
    logic [31:0] r_wd;
    logic [3:0]  r_be;
    int          r_stall;

    initial begin
        vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 5'd3,  32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd3,  32'h11223344, 4'h5, 32'h0};
        vecs[3]  = '{1'b0, 5'd3,  32'h0,        4'hF, 32'hDE22BE44};
        vecs[4]  = '{1'b1, 5'd7,  32'hCAFEF00D, 4'hF, 32'h0};
        vecs[5]  = '{1'b0, 5'd7,  32'h0,        4'h0, 32'hCAFEF00D};
        vecs[6]  = '{1'b1, 5'd7,  32'h12345678, 4'h0, 32'h0};
        vecs[7]  = '{1'b0, 5'd7,  32'h0,        4'h0, 32'hCAFEF00D};
        vecs[8]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 4'hF, 32'h0};
        vecs[9]  = '{1'b1, 5'd31, 32'h000000FF, 4'h1, 32'h0};
        vecs[10] = '{1'b0, 5'd31, 32'h0,        4'h0, 32'hA5A5A5FF};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        4'h0, 32'h0};

        Reset = 1'b0;
        bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqAdr = '0;
        bus.ReqWData = '0;   bus.ReqBe = '0;      bus.RspReady = 1'b0;
        b0.ReqValid  = 1'b0; b0.ReqWrite  = 1'b0; b0.ReqAdr  = '0;
        b0.ReqWData  = '0;   b0.ReqBe     = '0;   b0.RspReady = 1'b0;

        // Reset values and release timing
        repeat (3) tick();
        chk("rst ReqReady", {31'd0, bus.ReqReady}, 32'd0);
        chk("rst RspValid", {31'd0, bus.RspValid}, 32'd0);
        chk("rst RspRData", bus.RspRData, 32'd0);
        chk("rst RspWrite", {31'd0, bus.RspWrite}, 32'd0);
        Reset = 1'b1;
        #1;
        chk("release ReqReady early", {31'd0, bus.ReqReady}, 32'd0);
        tick();
        chk("release ReqReady", {31'd0, bus.ReqReady}, 32'd1);
        chk("release RspValid", {31'd0, bus.RspValid}, 32'd0);

        // Zero-wait build: back-to-back with ReqValid and RspReady held high
        b0.RspReady = 1'b1;
        b0.ReqValid = 1'b1;
        b0.ReqWrite = 1'b1;
        b0.ReqAdr   = 5'd5;
        b0.ReqWData = 32'h13579BDF;
        b0.ReqBe    = 4'hF;
        for (int c = 0; c < 32; c++) begin
            chk("w0 ready&valid", {31'd0, b0.ReqReady & b0.RspValid}, 32'd0);
            if (b0.ReqValid && b0.ReqReady) acc_q.push_back(c);
            if (b0.RspValid && b0.RspReady) begin
                rsp_q.push_back(c);
                rdv_q.push_back(b0.RspRData);
                rwv_q.push_back(b0.RspWrite);
            end
            tick();
            if (acc_q.size() > 0) b0.ReqWrite = 1'b0;
        end
        b0.ReqValid = 1'b0;
        chk("w0 accepts", {31'd0, acc_q.size() >= 10}, 32'd1);
        chk("w0 responses", {31'd0, rsp_q.size() >= 10}, 32'd1);
        for (int i = 0; i + 1 < acc_q.size(); i++) chk("w0 accept spacing", acc_q[i+1] - acc_q[i], 3);
        for (int i = 0; i < rsp_q.size() && i < acc_q.size(); i++) begin
            chk("w0 rsp timing", rsp_q[i], acc_q[i] + 2);
            chk("w0 rdata", rdv_q[i], (i == 0) ? 32'd0 : 32'h13579BDF);
            chk("w0 rwrite", {31'd0, rwv_q[i]}, (i == 0) ? 32'd1 : 32'd0);
        end

        // Give every word a known value before directed and random traffic
        for (int a = 0; a < 32; a++) xact(1'b1, 5'(a), $urandom, 4'hF, 32'd0, 0, "init");
        for (int i = 0; i < NV; i++) begin
            if (i == 11) vecs[i].exp_rd = model[0];
            xact(vecs[i].wr, vecs[i].adr, vecs[i].wd, vecs[i].be, vecs[i].exp_rd, 0, "vec");
        end

        // Long response stall; concurrent requests must be ignored
        xact(1'b0, 5'd3, 32'd0, 4'd0, 32'hDE22BE44, 10, "stall10");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post-stall idle valid", {31'd0, bus.RspValid}, 32'd0);
            chk("post-stall idle ready", {31'd0, bus.ReqReady}, 32'd1);
        end

        // Reset during WAIT of a store to adr 7 discards it
        wait_ready("rst-wait");
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqAdr = 5'd7;
        bus.ReqWData = 32'h0BADF00D; bus.ReqBe = 4'hF; bus.RspReady = 1'b1;
        tick();
        bus.ReqValid = 1'b0;
        tick();
        Reset = 1'b0;
        #1;
        chk("rst-wait RspValid", {31'd0, bus.RspValid}, 32'd0);
        chk("rst-wait ReqReady", {31'd0, bus.ReqReady}, 32'd0);
        tick(); tick();
        Reset = 1'b1;
        tick();
        xact(1'b0, 5'd7, 32'd0, 4'd0, 32'hCAFEF00D, 0, "rst-wait load7");

        // Reset while a response is pending drops RspValid at once
        wait_ready("rst-resp");
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqAdr = 5'd3; bus.RspReady = 1'b0;
        tick();
        bus.ReqValid = 1'b0;
        repeat (W + 1) tick();
        chk("rst-resp pending", {31'd0, bus.RspValid}, 32'd1);
        Reset = 1'b0;
        #1;
        chk("rst-resp RspValid", {31'd0, bus.RspValid}, 32'd0);
        chk("rst-resp RspRData", bus.RspRData, 32'd0);
        tick();
        Reset = 1'b1;
        tick();

        // Random traffic against the reference array
        for (int k = 0; k < 40; k++) begin
            r_wr    = 1'($urandom);
            r_adr   = 5'($urandom);
            r_wd    = $urandom;
            r_be    = 4'($urandom);
            r_stall = $urandom_range(0, 3);
            xact(r_wr, r_adr, r_wd, r_be, model[r_adr], r_stall, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
